// File: rtl/accum_scheduler_if.sv
// accum_scheduler_if: request, element-stream and result signals of the shared reduction scheduler
interface accum_scheduler_if #(
    parameter int data_width = 16,
    parameter int NUM_REQ    = 4,
    parameter int MAX_LEN    = 64,
    parameter int LW         = $clog2(MAX_LEN + 1),
    parameter int IW         = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]                 req_valid, req_ready, in_valid, in_ready;
    logic [NUM_REQ-1:0][LW-1:0]         req_len;
    logic [NUM_REQ-1:0][data_width-1:0] in_data;
    logic                               out_valid, out_ready, busy;
    logic [data_width-1:0]              out_data;
    logic [IW-1:0]                      out_id;
    modport master (
        output req_valid, req_len, in_valid, in_data, out_ready,
        input  req_ready, in_ready, out_valid, out_data, out_id, busy
    );
    modport slave (
        input  req_valid, req_len, in_valid, in_data, out_ready,
        output req_ready, in_ready, out_valid, out_data, out_id, busy
    );
endinterface

// File: rtl/accum_scheduler.sv
// accum_scheduler: round-robin arbiter streaming requesters' FP16 elements through one shared adder
module new_fp16_add (
    input  logic [31:0] ab_i,
    output logic [15:0] sum_o
);
    logic [15:0] a, b, x, y;
    logic [4:0]  ex, ey, d, lz, sh;
    logic [13:0] mx, my, my_sh, msk, n;
    logic [14:0] s, rnd;
    logic [5:0]  e;
    logic        sub, up, a_nan, b_nan, a_inf, b_inf;
    always_comb begin
        a     = ab_i[31:16];
        b     = ab_i[15:0];
        x     = (a[14:0] >= b[14:0]) ? a : b;
        y     = (a[14:0] >= b[14:0]) ? b : a;
        ex    = (x[14:10] == 5'd0) ? 5'd1 : x[14:10];
        ey    = (y[14:10] == 5'd0) ? 5'd1 : y[14:10];
        mx    = {x[14:10] != 5'd0, x[9:0], 3'b000};
        my    = {y[14:10] != 5'd0, y[9:0], 3'b000};
        d     = ex - ey;
        msk   = ~(14'h3FFF << d);
        // bits shifted out of the smaller operand collapse into a sticky lsb
        my_sh = (my >> d) | {13'd0, |(my & msk)};
        sub   = x[15] ^ y[15];
        s     = sub ? {1'b0, mx} - {1'b0, my_sh} : {1'b0, mx} + {1'b0, my_sh};
        lz    = 5'd14;
        for (int i = 0; i < 14; i++) if (s[i]) lz = 5'(13 - i);
        sh    = (lz < ex - 5'd1) ? lz : ex - 5'd1;
        n     = s[14] ? {s[14:2], s[1] | s[0]} : s[13:0] << sh;
        e     = s[14] ? {1'b0, ex} + 6'd1 : {1'b0, ex - sh};
        e     = n[13] ? e : 6'd0;
        up    = n[2] & (n[1] | n[0] | n[3]);
        rnd   = {e[4:0], n[12:3]} + {14'd0, up};
        a_nan = (&a[14:10]) & (|a[9:0]);
        b_nan = (&b[14:10]) & (|b[9:0]);
        a_inf = (&a[14:10]) & ~(|a[9:0]);
        b_inf = (&b[14:10]) & ~(|b[9:0]);
        sum_o = (a_nan | b_nan | (a_inf & b_inf & sub)) ? 16'h7E00 :
                a_inf                                   ? a :
                b_inf                                   ? b :
                (s == 15'd0)                            ? {x[15] & y[15], 15'd0} :
                (e >= 6'd31)                            ? {x[15], 15'h7C00} :
                                                          {x[15], rnd};
    end
endmodule

module accum_scheduler #(
    parameter int data_width = 16,
    parameter int NUM_REQ    = 4,
    parameter int MAX_LEN    = 64
) (
    input logic              clk,
    input logic              rst,
    accum_scheduler_if.slave bus
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int IW = $clog2(NUM_REQ);
    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;
    state_t                state_q, state_d;
    logic [data_width-1:0] acc_q, acc_d, sum;
    logic [LW-1:0]         cnt_q, cnt_d, len_q, len_d, glen;
    logic [IW-1:0]         id_q, id_d, rr_q, rr_d, gid;
    logic                  gnt;
    new_fp16_add u_add (.ab_i({acc_q, bus.in_data[id_q]}), .sum_o(sum));
    // descending scan so the requester closest after rr_q wins
    always_comb begin
        gnt = 1'b0;
        gid = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (bus.req_valid[IW'((int'(rr_q) + k) % NUM_REQ)]) begin
                gnt = 1'b1;
                gid = IW'((int'(rr_q) + k) % NUM_REQ);
            end
        end
        glen = (bus.req_len[gid] > LW'(MAX_LEN)) ? LW'(MAX_LEN) : bus.req_len[gid];
    end
    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        len_d         = len_q;
        id_d          = id_q;
        rr_d          = rr_q;
        bus.req_ready = '0;
        bus.in_ready  = '0;
        case (state_q)
            IDLE: if (gnt) begin
                bus.req_ready = NUM_REQ'(1) << gid;
                id_d          = gid;
                len_d         = glen;
                acc_d         = '0;
                cnt_d         = '0;
                state_d       = (glen == '0) ? OUT : ACC;
            end
            ACC: begin
                bus.in_ready = NUM_REQ'(1) << id_q;
                if (bus.in_valid[id_q]) begin
                    acc_d   = sum;
                    cnt_d   = cnt_q + LW'(1);
                    state_d = (cnt_q == len_q - LW'(1)) ? OUT : ACC;
                end
            end
            OUT: if (bus.out_ready) begin
                rr_d    = id_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            id_q    <= '0;
            rr_q    <= IW'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            id_q    <= id_d;
            rr_q    <= rr_d;
        end
    end
    assign bus.out_valid = (state_q == OUT);
    assign bus.out_data  = bus.out_valid ? acc_q : '0;
    assign bus.out_id    = bus.out_valid ? id_q : '0;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_accum_scheduler.sv
// tb_accum_scheduler: directed vectors and hand sequences for the shared FP16 reduction scheduler
module tb_accum_scheduler;
    localparam int DW = 16, NR = 4, ML = 64, LW = $clog2(ML + 1);
    logic clk = 1'b0, rst = 1'b0;
    always #5 clk = ~clk;
    accum_scheduler_if #(.data_width(DW), .NUM_REQ(NR), .MAX_LEN(ML)) bus ();
    accum_scheduler #(.data_width(DW), .NUM_REQ(NR), .MAX_LEN(ML)) dut (.clk(clk), .rst(rst), .bus(bus));
    typedef struct packed {
        logic [1:0]        id;
        logic [6:0]        len;
        logic [1:0]        gap;
        logic [0:3][15:0]  el;
        logic [15:0]       sum;
    } vec_t;
    vec_t        vecs [10];
    logic [15:0] ebuf [64];
    int          n_vec = 0, n_fail = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic run_req(input int id, input int len, input int n, input int gap, input logic [15:0] exp);
        bit got = 1'b0;
        bus.req_valid[id] = 1'b1;
        bus.req_len[id]   = LW'(len);
        for (int t = 0; t < 20 && !got; t++) begin
            #1 got = bus.req_ready[id];
            tick();
        end
        chk("grant", 32'(got), 32'd1);
        bus.req_valid[id] = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.in_valid = '0;
            repeat (gap) tick();
            bus.in_valid[id] = 1'b1;
            bus.in_data[id]  = ebuf[i];
            #1 chk("in_ready", 32'(bus.in_ready), 32'(1 << id));
            tick();
        end
        bus.in_valid = '0;
        #1;
        chk("out_valid", 32'(bus.out_valid), 32'd1);
        chk("out_data", 32'(bus.out_data), 32'(exp));
        chk("out_id", 32'(bus.out_id), 32'(id));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        #1 chk("out_valid_drop", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        vecs[0] = '{2'd0, 7'd4, 2'd0, {16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00}, 16'h4400};
        vecs[1] = '{2'd2, 7'd0, 2'd0, {16'h0000, 16'h0000, 16'h0000, 16'h0000}, 16'h0000};
        vecs[2] = '{2'd1, 7'd3, 2'd2, {16'h3C00, 16'h4000, 16'hC000, 16'h0000}, 16'h3C00};
        vecs[3] = '{2'd1, 7'd2, 2'd0, {16'h3E00, 16'h3800, 16'h0000, 16'h0000}, 16'h4000};
        vecs[4] = '{2'd3, 7'd3, 2'd1, {16'h4000, 16'h4200, 16'h3C00, 16'h0000}, 16'h4600};
        vecs[5] = '{2'd0, 7'd1, 2'd0, {16'hC400, 16'h0000, 16'h0000, 16'h0000}, 16'hC400};
        vecs[6] = '{2'd2, 7'd2, 2'd0, {16'h3C00, 16'hBC00, 16'h0000, 16'h0000}, 16'h0000};
        vecs[7] = '{2'd3, 7'd2, 2'd0, {16'h0001, 16'h0001, 16'h0000, 16'h0000}, 16'h0002};
        vecs[8] = '{2'd1, 7'd2, 2'd0, {16'h7BFF, 16'h7BFF, 16'h0000, 16'h0000}, 16'h7C00};
        vecs[9] = '{2'd0, 7'd2, 2'd0, {16'h7C00, 16'hFC00, 16'h0000, 16'h0000}, 16'h7E00};
        bus.req_valid = '0;
        bus.req_len   = '0;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        chk("reset_outs", {bus.req_ready, bus.in_ready, bus.out_valid, bus.busy, bus.out_data, bus.out_id},
            32'd0);
        rst = 1'b1;
        tick();
        // all four request at once; re-requesting winner drops to lowest priority
        bus.req_valid = 4'hF;
        for (int k = 0; k < NR; k++) bus.req_len[k] = LW'(1);
        bus.in_data = {16'h4400, 16'h4200, 16'h4000, 16'h3C00};
        for (int k = 0; k < 5; k++) begin
            #1 chk("rr_grant", 32'(bus.req_ready), 32'(1 << (k % 4)));
            tick();
            bus.in_valid = 4'hF;
            #1 chk("rr_in_ready", 32'(bus.in_ready), 32'(1 << (k % 4)));
            tick();
            bus.in_valid = '0;
            #1 chk("rr_out_id", 32'(bus.out_id), 32'(k % 4));
            chk("rr_out_data", 32'(bus.out_data), 32'(bus.in_data[k % 4]));
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
        end
        bus.req_valid = '0;
        tick();
        for (int v = 0; v < 10; v++) begin
            for (int i = 0; i < 4; i++) ebuf[i] = vecs[v].el[i];
            run_req(int'(vecs[v].id), int'(vecs[v].len), int'(vecs[v].len), int'(vecs[v].gap), vecs[v].sum);
        end
        // oversize length clamps to MAX_LEN beats
        for (int i = 0; i < 64; i++) ebuf[i] = 16'h3C00;
        run_req(2, 100, 64, 0, 16'h5400);
        // result held under backpressure, pending request waits for handshake
        bus.req_valid = 4'b0010;
        bus.req_len[1] = LW'(1);
        bus.req_len[3] = LW'(1);
        #1 chk("hold_grant", 32'(bus.req_ready), 32'h2);
        tick();
        bus.req_valid = 4'b1000;
        bus.in_valid[1] = 1'b1;
        bus.in_data[1]  = 16'h4000;
        tick();
        bus.in_valid = '0;
        for (int c = 0; c < 5; c++) begin
            #1 chk("hold_state", {bus.out_valid, bus.req_ready, bus.out_id, bus.out_data},
                   {1'b1, 4'h0, 2'd1, 16'h4000});
            tick();
        end
        bus.out_ready = 1'b1;
        #1 chk("hold_no_grant", 32'(bus.req_ready), 32'h0);
        tick();
        bus.out_ready = 1'b0;
        #1 chk("hold_next_grant", 32'(bus.req_ready), 32'h8);
        tick();
        bus.req_valid = '0;
        bus.in_valid[3] = 1'b1;
        bus.in_data[3]  = 16'h3C00;
        tick();
        bus.in_valid = '0;
        #1 chk("hold_next_out", {bus.out_valid, bus.out_id, bus.out_data}, {1'b1, 2'd3, 16'h3C00});
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        // asynchronous reset in the middle of a reduction discards it
        bus.req_valid = 4'b0001;
        bus.req_len[0] = LW'(8);
        #1 chk("rst_grant", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = '0;
        bus.in_valid[0] = 1'b1;
        bus.in_data[0]  = 16'h4000;
        tick();
        tick();
        rst = 1'b0;
        #1 chk("mid_reset_outs", {bus.req_ready, bus.in_ready, bus.out_valid, bus.busy, bus.out_data, bus.out_id},
               32'd0);
        bus.in_valid = '0;
        tick();
        rst = 1'b1;
        tick();
        #1 chk("post_reset_idle", {bus.out_valid, bus.busy}, 32'd0);
        ebuf[0] = 16'h3C00;
        run_req(0, 1, 1, 0, 16'h3C00);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
